timer_cnt_ctrl: RTL and testbench

Sequencing controller for the 64-bit timer counter. It consumes register-level controls decoded from APB `wr_en`/`rd_en` accesses and runs a run/idle/halt state machine and a power-of-two prescaler. It drives the counter increment and software counter loads, and generates the compare-match interrupt. It sits between the APB register bank and the timer interrupt output.

---
 rtl/timer_pkg.sv | 15 +
 rtl/timer_prescaler.sv | 52 +++++
 rtl/timer_cnt_ctrl.sv | 130 +++++++++++++
 tb/tb_timer_cnt_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the 64-bit timer counter controller.
package timer_pkg;

  localparam int CNT_W   = 64;
  localparam int DIV_W   = 4;
  // Largest prescaler exponent; larger selects saturate to this value.
  localparam int DIV_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } timer_state_e;

endpackage : timer_pkg

// File: rtl/timer_prescaler.sv
// Power-of-two prescaler: keeps div_cnt, decodes the tick limit from div_val,
// restarts when div_en/div_val change, and emits the counting tick.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int DIV_W = timer_pkg::DIV_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             run,
  input  logic             idle,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);

  logic [7:0]       div_cnt;
  logic [7:0]       limit;
  logic             div_en_q;
  logic [DIV_W-1:0] div_val_q;
  logic             changed;

  // Limit = 2^min(div_val, DIV_MAX) - 1; selects at or above DIV_MAX give 255.
  always_comb begin
    limit = 8'hFF;
    for (int i = 0; i < DIV_MAX; i++) begin
      if (div_val == DIV_W'(i)) limit = 8'((9'd1 << i) - 9'd1);
    end
  end

  // A reprogrammed divider restarts the period and suppresses that cycle's tick.
  assign changed = (div_en != div_en_q) || (div_val != div_val_q);
  assign tick    = run && !changed && (!div_en || (div_cnt == limit));

  // div_cnt: cleared in IDLE or on reprogramming, counts in RUN, frozen otherwise.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      div_cnt   <= 8'd0;
      div_en_q  <= 1'b0;
      div_val_q <= '0;
    end else begin
      div_en_q  <= div_en;
      div_val_q <= div_val;
      if (idle || changed) begin
        div_cnt <= 8'd0;
      end else if (run && div_en) begin
        div_cnt <= (div_cnt == limit) ? 8'd0 : div_cnt + 8'd1;
      end
    end
  end

endmodule : timer_prescaler

// File: rtl/timer_cnt_ctrl.sv
// Timer counter sequencing: IDLE/RUN/HALT state machine, 64-bit counter with
// software half-word loads, compare match and sticky interrupt status.
// Build option TIMER_DBG_HALT_EN: when defined, the debug HALT state and
// halt_req/halt_ack are built; otherwise halt_req is ignored and halt_ack is 0.
module timer_cnt_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W = timer_pkg::CNT_W,
  parameter int DIV_W = timer_pkg::DIV_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             cnt_wr_lo,
  input  logic             cnt_wr_hi,
  input  logic [31:0]      wdata,
  input  logic [CNT_W-1:0] cmp,
  input  logic             int_en,
  input  logic             int_clr,
  input  logic             halt_req,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_en,
  output logic             halt_ack,
  output logic             int_st,
  output logic             tim_int,
  output timer_state_e     dbg_state
);

  timer_state_e state;
  logic         tick;
  logic         load;
  logic         match;

  assign dbg_state = state;

`ifndef TIMER_DBG_HALT_EN
  logic unused_halt_req;
  assign unused_halt_req = halt_req;
  assign halt_ack        = 1'b0;
`endif

  // Run/idle/halt sequencing; dropping timer_en always wins over halt release.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= ST_IDLE;
`ifdef TIMER_DBG_HALT_EN
      halt_ack <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (timer_en) state <= ST_RUN;
        end
        ST_RUN: begin
          if (!timer_en) begin
            state <= ST_IDLE;
`ifdef TIMER_DBG_HALT_EN
          end else if (halt_req) begin
            state    <= ST_HALT;
            halt_ack <= 1'b1;
`endif
          end
        end
`ifdef TIMER_DBG_HALT_EN
        ST_HALT: begin
          if (!timer_en) begin
            state    <= ST_IDLE;
            halt_ack <= 1'b0;
          end else if (!halt_req) begin
            state    <= ST_RUN;
            halt_ack <= 1'b0;
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
`ifdef TIMER_DBG_HALT_EN
          halt_ack <= 1'b0;
`endif
        end
      endcase
    end
  end

  timer_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .run     (state == ST_RUN),
    .idle    (state == ST_IDLE),
    .div_en  (div_en),
    .div_val (div_val),
    .tick    (tick)
  );

  // A software load takes the cycle; cnt_en only reports real increments.
  assign load   = cnt_wr_lo | cnt_wr_hi;
  assign cnt_en = tick & ~load;

  // Counter: half-word loads beat the increment; all-ones wraps silently to 0.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (load) begin
      if (cnt_wr_lo) cnt[31:0]       <= wdata;
      if (cnt_wr_hi) cnt[CNT_W-1:32] <= wdata;
    end else if (cnt_en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign match = (cnt == cmp);

  // Sticky match status; a match in the same cycle overrides the clear strobe.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      int_st <= 1'b0;
    end else if (match) begin
      int_st <= 1'b1;
    end else if (int_clr) begin
      int_st <= 1'b0;
    end
  end

  assign tim_int = int_st & int_en;

endmodule : timer_cnt_ctrl

// File: tb/tb_timer_cnt_ctrl.sv
// Directed bench for timer_cnt_ctrl with a cycle model and per-cycle compare.
module tb_timer_cnt_ctrl;
  import timer_pkg::*;

  localparam int W = 64;
`ifdef TIMER_DBG_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic         sys_clk = 1'b0;
  logic         sys_rst = 1'b1;
  logic         timer_en = 1'b0;
  logic         div_en = 1'b0;
  logic [3:0]   div_val = 4'd0;
  logic         cnt_wr_lo = 1'b0;
  logic         cnt_wr_hi = 1'b0;
  logic [31:0]  wdata = 32'd0;
  logic [W-1:0] cmp = 64'hDEAD_0000_0000_0000;
  logic         int_en = 1'b0;
  logic         int_clr = 1'b0;
  logic         halt_req = 1'b0;
  logic [W-1:0] cnt;
  logic         cnt_en;
  logic         halt_ack;
  logic         int_st;
  logic         tim_int;
  timer_state_e dbg_state;

  always #5 sys_clk = ~sys_clk;

  timer_cnt_ctrl dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .timer_en  (timer_en),
    .div_en    (div_en),
    .div_val   (div_val),
    .cnt_wr_lo (cnt_wr_lo),
    .cnt_wr_hi (cnt_wr_hi),
    .wdata     (wdata),
    .cmp       (cmp),
    .int_en    (int_en),
    .int_clr   (int_clr),
    .halt_req  (halt_req),
    .cnt       (cnt),
    .cnt_en    (cnt_en),
    .halt_ack  (halt_ack),
    .int_st    (int_st),
    .tim_int   (tim_int),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_cnt;
  logic [W-1:0] m_nxt;
  bit           m_run, m_halt, m_int_st, m_tick, m_chg;
  int           m_ph;
  logic         m_den_q;
  logic [3:0]   m_dval_q;
  logic [W-1:0] exp_q[$];

  function automatic int period_of(input logic [3:0] dv);
    return 1 << ((dv > 4'd8) ? 8 : int'(dv));
  endfunction

  function automatic bit model_changed();
    return (div_en !== m_den_q) || (div_val !== m_dval_q);
  endfunction

  function automatic bit model_tick();
    return m_run && !model_changed() && (!div_en || (m_ph == period_of(div_val) - 1));
  endfunction

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_cnt = '0; m_run = 0; m_halt = 0; m_int_st = 0; m_ph = 0;
      m_den_q = 0; m_dval_q = 0;
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      m_tick = model_tick();
      m_chg  = model_changed();
      m_nxt  = m_cnt;
      if (cnt_wr_lo) m_nxt[31:0] = wdata;
      if (cnt_wr_hi) m_nxt[63:32] = wdata;
      if (!cnt_wr_lo && !cnt_wr_hi && m_tick) m_nxt = m_cnt + 64'd1;
      if (m_cnt == cmp) m_int_st = 1;
      else if (int_clr) m_int_st = 0;
      if (!m_run && !m_halt) m_ph = 0;
      else if (m_chg) m_ph = 0;
      else if (m_run && div_en) m_ph = (m_ph == period_of(div_val) - 1) ? 0 : m_ph + 1;
      if (!m_run && !m_halt) m_run = timer_en;
      else if (!timer_en) begin m_run = 0; m_halt = 0; end
      else if (m_run && HALT_EN && halt_req) begin m_run = 0; m_halt = 1; end
      else if (m_halt && !halt_req) begin m_run = 1; m_halt = 0; end
      m_den_q  = div_en;
      m_dval_q = div_val;
      m_cnt    = m_nxt;
      exp_q.push_back(m_nxt);
    end
  end

  // ---------------- scoreboard: compare every cycle ----------------
  always @(negedge sys_clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!sys_rst) begin
        check("cnt", cnt, e);
        check("cnt_en", cnt_en, model_tick() && !(cnt_wr_lo || cnt_wr_hi));
        check("halt_ack", halt_ack, m_halt);
        check("int_st", int_st, m_int_st);
        check("tim_int", tim_int, m_int_st && int_en);
        check("state", dbg_state, m_halt ? ST_HALT : (m_run ? ST_RUN : ST_IDLE));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  task automatic lit_cnt(input string name, input logic [63:0] req);
    check(name, cnt, req);
    check({"model_", name}, m_cnt, req);
  endtask

  task automatic summary();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    n_errors++;
    summary();
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    step(3);
    sys_rst = 1'b0;
    check("rst_cnt", cnt, 64'd0);
    check("rst_cnt_en", cnt_en, 1'b0);
    check("rst_halt_ack", halt_ack, 1'b0);
    check("rst_int_st", int_st, 1'b0);
    check("rst_tim_int", tim_int, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);

    // divider off: 10 cycles enabled gives 9 increments
    timer_en = 1'b1;
    step(10);
    lit_cnt("run10", 64'd9);

    // period 4: restart cycle, then ticks every 4th cycle
    div_en = 1'b1; div_val = 4'd2;
    step(17);
    lit_cnt("div4", 64'd13);

    // select 12 saturates to period 256
    div_val = 4'd12;
    step(256);
    lit_cnt("div256_before", 64'd13);
    step(1);
    lit_cnt("div256_tick", 64'd14);

    timer_en = 1'b0;
    step(2);
    lit_cnt("idle_hold", 64'd14);
    check("idle_state", dbg_state, ST_IDLE);

    // wrap from all-ones
    div_en = 1'b0; div_val = 4'd0;
    cnt_wr_lo = 1'b1; cnt_wr_hi = 1'b1; wdata = 32'hFFFF_FFFF;
    step(1);
    cnt_wr_lo = 1'b0; cnt_wr_hi = 1'b0;
    lit_cnt("load_ones", 64'hFFFF_FFFF_FFFF_FFFF);
    timer_en = 1'b1;
    step(1);
    lit_cnt("run_entry", 64'hFFFF_FFFF_FFFF_FFFF);
    step(1);
    lit_cnt("wrap", 64'd0);

    // high-half load in a tick cycle: no increment of the low half
    cnt_wr_hi = 1'b1; wdata = 32'h1;
    step(1);
    cnt_wr_hi = 1'b0;
    lit_cnt("load_hi", 64'h1_0000_0000);
    step(1);
    lit_cnt("after_load", 64'h1_0000_0001);

    // interrupt: match, clear blocked by match, clear after match gone
    timer_en = 1'b0;
    step(1);
    cnt_wr_hi = 1'b1; wdata = 32'h0;
    step(1);
    cnt_wr_hi = 1'b0;
    cmp = 64'd5; int_en = 1'b1;
    cnt_wr_lo = 1'b1; wdata = 32'd5;
    step(1);
    cnt_wr_lo = 1'b0;
    check("pre_match_tim_int", tim_int, 1'b0);
    step(1);
    check("match_tim_int", tim_int, 1'b1);
    int_clr = 1'b1;
    step(1);
    int_clr = 1'b0;
    check("clr_during_match", int_st, 1'b1);
    cnt_wr_lo = 1'b1; wdata = 32'd6;
    step(1);
    cnt_wr_lo = 1'b0;
    int_clr = 1'b1;
    step(1);
    int_clr = 1'b0;
    check("clr_int_st", int_st, 1'b0);
    check("clr_tim_int", tim_int, 1'b0);

    // halt
    cnt_wr_lo = 1'b1; wdata = 32'd18;
    step(1);
    cnt_wr_lo = 1'b0;
    timer_en = 1'b1;
    step(2);
    lit_cnt("pre_halt", 64'd19);
    halt_req = 1'b1;
    step(1);
    lit_cnt("halt_enter", 64'd20);
    check("halt_ack_on", halt_ack, HALT_EN);
    step(8);
    lit_cnt("halt_hold", HALT_EN ? 64'd20 : 64'd28);
    halt_req = 1'b0;
    step(2);
    lit_cnt("halt_resume", HALT_EN ? 64'd21 : 64'd30);
    check("halt_ack_off", halt_ack, 1'b0);

    // asynchronous reset mid-count
    #1;
    sys_rst = 1'b1;
    #1;
    check("arst_cnt", cnt, 64'd0);
    check("arst_cnt_en", cnt_en, 1'b0);
    check("arst_halt_ack", halt_ack, 1'b0);
    check("arst_int_st", int_st, 1'b0);
    check("arst_tim_int", tim_int, 1'b0);
    step(2);
    sys_rst = 1'b0;
    check("arst_state", dbg_state, ST_IDLE);
    timer_en = 1'b0;
    step(3);

    summary();
    $finish;
  end

endmodule : tb_timer_cnt_ctrl
